// File: rtl/i4004_bus_pkg.sv
// Shared definitions for the i4004 bus controller: slot encodings,
// opcode (OPR/OPA) constants and the two-word instruction predicate.
package i4004_bus_pkg;

    typedef enum logic [2:0] {
        SLOT_A1 = 3'd0,
        SLOT_A2 = 3'd1,
        SLOT_A3 = 3'd2,
        SLOT_M1 = 3'd3,
        SLOT_M2 = 3'd4,
        SLOT_E1 = 3'd5,
        SLOT_E2 = 3'd6,
        SLOT_E3 = 3'd7
    } slot_e;

    localparam int NSLOT = 8;

    localparam logic [3:0] OPR_JCN = 4'h1;
    localparam logic [3:0] OPR_FIM = 4'h2;
    localparam logic [3:0] OPR_FIN = 4'h3;
    localparam logic [3:0] OPR_JUN = 4'h4;
    localparam logic [3:0] OPR_JMS = 4'h5;
    localparam logic [3:0] OPR_ISZ = 4'h7;
    localparam logic [3:0] OPR_IO  = 4'hE;

    localparam logic [3:0] OPA_WRR = 4'h2;
    localparam logic [3:0] OPA_RDR = 4'hA;

    // FIM and FIN share their OPR with SRC and JIN; OPA[0]=0 selects
    // the two-word forms.
    function automatic logic is_two_word(input logic [7:0] w);
        logic [3:0] opr;
        logic       opa0;
        opr  = w[7:4];
        opa0 = w[0];
        return (opr == OPR_JCN) || (opr == OPR_JUN) ||
               (opr == OPR_JMS) || (opr == OPR_ISZ) ||
               (((opr == OPR_FIM) || (opr == OPR_FIN)) && !opa0);
    endfunction

endpackage

// File: rtl/i4004_mem_ctrl_if.sv
// Bundle of the controller's CPU-control, ROM and I/O-port signals.
// master: CPU/ROM/port side; slave: the memory controller.
interface i4004_mem_ctrl_if;

    logic        sync;
    logic        cm_rom;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [3:0]  io_port;
    logic [3:0]  io_wdata;
    logic        io_wr;
    logic        io_rd;
    logic [3:0]  io_rdata;
    logic        locked;
    logic        sync_err;

    modport master (
        output sync, cm_rom, mem_rdata, io_rdata,
        input  mem_addr, mem_rd, io_port, io_wdata,
        input  io_wr, io_rd, locked, sync_err
    );

    modport slave (
        input  sync, cm_rom, mem_rdata, io_rdata,
        output mem_addr, mem_rd, io_port, io_wdata,
        output io_wr, io_rd, locked, sync_err
    );

endinterface

// File: rtl/i4004_slot_timer.sv
// Instruction-cycle slot counter locked to sync.
// Ports: clk_i, rst_ni, sync_i -> slot_oh_o (one-hot, zero while
// unlocked), locked_o, sync_err_o (sticky), resync_o (unexpected sync).
module i4004_slot_timer
    import i4004_bus_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sync_i,
    output logic [NSLOT-1:0] slot_oh_o,
    output logic             locked_o,
    output logic             sync_err_o,
    output logic             resync_o
);

    slot_e slot_q;
    slot_e slot_d;
    logic  locked_q;
    logic  err_q;

    // Only a sync after lock can be "unexpected"; the first one locks.
    assign resync_o = sync_i && locked_q && (slot_q != SLOT_E3);

    always_comb begin
        slot_d = sync_i ? SLOT_A1 : slot_e'(slot_q + 3'd1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q   <= SLOT_A1;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            slot_q <= slot_d;
            if (sync_i) begin
                locked_q <= 1'b1;
            end
            if (resync_o) begin
                err_q <= 1'b1;
            end
        end
    end

    // Gating by lock keeps every downstream slot action idle until locked.
    always_comb begin
        slot_oh_o = '0;
        if (locked_q) begin
            slot_oh_o[slot_q] = 1'b1;
        end
    end

    assign locked_o   = locked_q;
    assign sync_err_o = err_q;

endmodule

// File: rtl/i4004_mem_ctrl.sv
// i4004 memory and I/O bus controller: address demux, ROM fetch,
// two-word tracking and SRC/WRR/RDR port transfers.
// Ports: cp2 clock, reset (async active-low), data (CPU bus), bus (slave).
module i4004_mem_ctrl
    import i4004_bus_pkg::*;
#(
    parameter int unsigned IO_EN = 1
)
(
    input  logic            cp2,
    input  logic            reset,
    inout  wire  [3:0]      data,
    i4004_mem_ctrl_if.slave bus
);

    localparam bit IoOn = (IO_EN != 0);

    logic [NSLOT-1:0] slot_oh;
    logic             resync;

    logic [7:0]  addr_q;
    logic [11:0] mem_addr_q;
    logic        fetch_v_q;
    logic [3:0]  word_q;
    logic        second_q;
    logic        src_q;
    logic        wrr_q;
    logic        rdr_q;
    logic [7:0]  src_addr_q;
    logic [3:0]  io_wdata_q;

    logic        dec_src;
    logic        dec_wrr;
    logic        dec_rdr;
    logic        data_oe;
    logic [3:0]  data_out;

    logic s_a1, s_a2, s_a3, s_m1, s_m2, s_e2, s_e3;

    i4004_slot_timer u_timer (
        .clk_i      (cp2),
        .rst_ni     (reset),
        .sync_i     (bus.sync),
        .slot_oh_o  (slot_oh),
        .locked_o   (bus.locked),
        .sync_err_o (bus.sync_err),
        .resync_o   (resync)
    );

    assign s_a1 = slot_oh[SLOT_A1];
    assign s_a2 = slot_oh[SLOT_A2];
    assign s_a3 = slot_oh[SLOT_A3];
    assign s_m1 = slot_oh[SLOT_M1];
    assign s_m2 = slot_oh[SLOT_M2];
    assign s_e2 = slot_oh[SLOT_E2];
    assign s_e3 = slot_oh[SLOT_E3];

    // A word that is the operand of a two-word instruction is never decoded.
    always_comb begin
        dec_src = 1'b0;
        dec_wrr = 1'b0;
        dec_rdr = 1'b0;
        if (IoOn && !second_q) begin
            dec_src = (bus.mem_rdata[7:4] == OPR_FIM) && bus.mem_rdata[0];
            dec_wrr = (bus.mem_rdata[7:4] == OPR_IO) &&
                      (bus.mem_rdata[3:0] == OPA_WRR);
            dec_rdr = (bus.mem_rdata[7:4] == OPR_IO) &&
                      (bus.mem_rdata[3:0] == OPA_RDR);
        end
    end

    always_ff @(posedge cp2 or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            mem_addr_q <= '0;
            fetch_v_q  <= 1'b0;
            word_q     <= '0;
            second_q   <= 1'b0;
            src_q      <= 1'b0;
            wrr_q      <= 1'b0;
            rdr_q      <= 1'b0;
            src_addr_q <= '0;
            io_wdata_q <= '0;
        end else begin
            if (s_a1) begin
                addr_q[3:0] <= data;
            end
            if (s_a2) begin
                addr_q[7:4] <= data;
            end
            // High nibble bypasses addr_q so the ROM sees it from M1.
            if (s_a3) begin
                fetch_v_q <= bus.cm_rom;
                if (bus.cm_rom) begin
                    mem_addr_q <= {data, addr_q};
                end
            end
            if (s_m1) begin
                src_q <= 1'b0;
                wrr_q <= 1'b0;
                rdr_q <= 1'b0;
                if (fetch_v_q) begin
                    word_q   <= bus.mem_rdata[3:0];
                    second_q <= second_q ? 1'b0
                                         : is_two_word(bus.mem_rdata);
                    src_q    <= dec_src;
                    wrr_q    <= dec_wrr;
                    rdr_q    <= dec_rdr;
                end
            end
            if (s_m2) begin
                fetch_v_q <= 1'b0;
            end
            if (s_e2) begin
                if (wrr_q) begin
                    io_wdata_q <= data;
                end
                if (src_q && bus.cm_rom) begin
                    src_addr_q[7:4] <= data;
                end
            end
            if (s_e3 && src_q && bus.cm_rom) begin
                src_addr_q[3:0] <= data;
            end
            // Lost cycle alignment: abandon whatever this cycle had pending.
            if (resync) begin
                fetch_v_q <= 1'b0;
                second_q  <= 1'b0;
                src_q     <= 1'b0;
                wrr_q     <= 1'b0;
                rdr_q     <= 1'b0;
            end
        end
    end

    always_comb begin
        data_oe  = 1'b0;
        data_out = '0;
        unique case (1'b1)
            s_m1 && fetch_v_q: begin
                data_oe  = 1'b1;
                data_out = bus.mem_rdata[7:4];
            end
            s_m2 && fetch_v_q: begin
                data_oe  = 1'b1;
                data_out = word_q;
            end
            s_e2 && rdr_q: begin
                data_oe  = 1'b1;
                data_out = bus.io_rdata;
            end
            default: begin
                data_oe  = 1'b0;
                data_out = '0;
            end
        endcase
    end

    assign data = data_oe ? data_out : 4'bzzzz;

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_rd   = s_m1 && fetch_v_q;
    assign bus.io_port  = src_addr_q[7:4];
    assign bus.io_wdata = io_wdata_q;
    assign bus.io_wr    = s_e2 && wrr_q;
    assign bus.io_rd    = s_e2 && rdr_q;

    // E1 needs no action; the SRC low nibble is kept for the port pair.
    logic unused;
    assign unused = ^{slot_oh[SLOT_E1], src_addr_q[3:0]};

endmodule

// File: doc/i4004_mem_ctrl.md
# i4004_mem_ctrl

Memory and I/O bus controller on the i4004 4-bit multiplexed data bus. It tracks the 8-slot instruction cycle from `sync` and demultiplexes the three address nibbles into a 12-bit program-memory address. It returns the 8-bit instruction word as two nibbles, and executes SRC/WRR/RDR I/O port transfers. It sits between the CPU's `data` pins and an asynchronous program ROM plus a bank of 4-bit output/input ports.

## Interface
Parameters:
- `IO_EN`, default 1: when 0, SRC/WRR/RDR decoding is disabled; `io_wr`/`io_rd` are held 0 and the controller never drives the bus in E2.

Ports:
- `cp2`  in  1  single clock; one slot per cycle, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sync`  in  1  active-high for exactly one cycle, in slot E3; next slot is A1.
- `cm_rom`  in  1  active-high ROM command line, sampled in A3 and E2.
- `data`  inout  4  multiplexed CPU bus; this block drives it only as specified below, otherwise hi-Z.
- `mem_addr`  out  12  registered program address.
- `mem_rd`  out  1  read strobe, high for the M1 slot only.
- `mem_rdata`  in  8  asynchronous ROM data, valid in the same cycle as `mem_rd`.
- `io_port`  out  4  port number, equal to `src_addr[7:4]`.
- `io_wdata`  out  4  write data, held until the next WRR.
- `io_wr`  out  1  one-cycle write strobe.
- `io_rd`  out  1  one-cycle read strobe.
- `io_rdata`  in  4  input port data, sampled combinationally during E2.
- `locked`  out  1  slot counter is synchronised to `sync`.
- `sync_err`  out  1  sticky flag; `sync` was seen outside the predicted E3.

## Operation
- Slot counter: 3 bits, counting A1, A2, A3, M1, M2, E1, E2, E3 (encodings 0..7); advances by one each cycle and wraps E3 to A1.
- Lock: `locked=0` after reset. The first `sync` sets `locked=1` and forces the next slot to A1. While unlocked, the block drives nothing and raises no strobes.
- Resync: if `sync=1` while the slot is not E3, the next slot is A1, `sync_err` is set, and the current cycle's pending I/O is dropped.
- Address capture: in A1, A2 and A3, sample `data` into `addr_q[3:0]`, `[7:4]` and `[11:8]` respectively. At the end of A3, if `cm_rom=1`, load `mem_addr` from `addr_q`, and set `fetch_v` for the M1 slot.
- Fetch, when `fetch_v=1`:
  - In M1, `mem_rd=1`, drive `data=mem_rdata[7:4]`, and capture `mem_rdata` into `word_q`.
  - In M2, drive `data=word_q[3:0]`.
  - With `fetch_v=0`, the bus stays hi-Z and `mem_rd=0`.
- Two-word tracking:
  - If the fetched word is an opcode with OPR in {1 JCN, 4 JUN, 5 JMS, 7 ISZ}, or OPR=2 with OPA[0]=0 (FIM), or OPR=3 with OPA[0]=0 (FIN), set `second_q`.
  - While `second_q=1`, the next fetched word is not decoded; `second_q` clears after that fetch.
- SRC (OPR=2, OPA[0]=1, not a second word): in E2 and E3 with `cm_rom=1`, sample `data` into `src_addr[7:4]` and `src_addr[3:0]` respectively.
- WRR (word 0xE2): in E2, `io_wdata<=data` and `io_wr=1` for that cycle.
- RDR (word 0xEA): in E2, drive `data=io_rdata` and `io_rd=1` for that cycle.
- Other 0xE_ words are ignored.

## Timing
- Reset values:
  - `mem_addr=0`, `mem_rd=0`, `io_port=0`, `io_wdata=0`, `io_wr=0`, `io_rd=0`, `locked=0`, `sync_err=0`.
  - `data` is hi-Z.
  - `second_q=0`, `src_addr=0`.
- Address-to-ROM latency: `mem_addr` is valid from the first cycle of M1, i.e. one cycle after the A3 sample.
- Bus drive windows: M1 and M2 only when `fetch_v=1`; E2 only for RDR. The bus is never driven in A1–A3, E1 or E3.
- `io_wr` and `io_rd` are strobes exactly one cycle long, in the E2 slot of the instruction's own cycle. They are never both high.
- Reset asserted mid-cycle:
  - Outputs return to reset values immediately.
  - A pending second word or I/O is discarded.
  - Relock is required.
- `sync` coinciding with an E2 strobe: the strobe still fires, then resync applies from the next cycle.
- `cm_rom=0` in E2 for SRC leaves `src_addr` unchanged.

## Structure
- Shared package `i4004_bus_pkg`:
  - slot encodings A1..E3;
  - OPR constants for JCN, FIM/SRC, FIN/JIN, JUN, JMS, ISZ and IO (0xE);
  - the WRR/RDR OPA codes;
  - the two-word predicate as a function.
- Sub-module `i4004_slot_timer`: slot counter, lock, resync and `sync_err`. Outputs a one-hot slot vector.
- The top level holds the address, fetch, decode and I/O logic.

## Test plan
- Lock: reset, apply `sync` every 8 cycles → `locked=1` after the first `sync`; the slot after `sync` is A1; `sync_err` stays 0.
- Fetch: bus A1=0x4, A2=0x2, A3=0x1 with `cm_rom=1`, `mem_rdata=0xD7` → `mem_addr=0x124`, `mem_rd` high in M1, bus reads 0xD in M1 and 0x7 in M2.
- Two-word: fetch 0x40 (JUN), then 0xE2, then 0xE2 → the first 0xE2 produces no `io_wr`; the second 0xE2 produces `io_wr`.
- SRC+WRR: fetch 0x21 with bus E2=0x5, E3=0x3, then 0xE2 with bus E2=0x9 → `src_addr=0x53`, `io_port=5`, `io_wdata=9`, one-cycle `io_wr`.
- RDR: after the SRC above, fetch 0xEA with `io_rdata=0xC` → `data=0xC` in E2 only; `io_rd` high for one cycle.
- Resync/reset: `sync` in slot M1 → `sync_err=1` and the next slot is A1; assert `reset` in M2 → `data` hi-Z and `locked=0` at once.
